ppg_fir_scheduler: RTL and testbench

Sequences the finger-clip measurement for both optical channels and time-shares a single FIR filter datapath between them. Alternates the IR and RED LEDs at a fixed phase length, triggers the ADC after an LED settle time, hands each captured sample to the shared FIR with a channel tag, and routes the filtered result to the matching per-channel output register. Sits between the ADC interface and the FIR datapath, upstream of the SpO2/pulse computation.

---
 rtl/ppg_fir_scheduler_if.sv | 22 ++
 rtl/ppg_fir_scheduler.sv | 158 +++++++++++++++
 tb/tb_ppg_fir_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ppg_fir_scheduler_if.sv
// ADC and shared-FIR handshake bundle for the PPG measurement scheduler.
// The scheduler drives the requests; the ADC/FIR side answers with done strobes.
interface ppg_fir_scheduler_if;
  logic        adc_start;
  logic        adc_done;
  logic [7:0]  ADC_Value;
  logic        fir_start;
  logic        fir_ch;
  logic [7:0]  fir_sample;
  logic        fir_done;
  logic [19:0] fir_result;

  modport master (
    output adc_start, fir_start, fir_ch, fir_sample,
    input  adc_done, ADC_Value, fir_done, fir_result
  );

  modport slave (
    input  adc_start, fir_start, fir_ch, fir_sample,
    output adc_done, ADC_Value, fir_done, fir_result
  );
endinterface

// File: rtl/ppg_fir_scheduler.sv
// Alternating IR/RED LED sequencer: settle, ADC capture, shared FIR pass, and
// per-channel result routing.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | LEDs off, waiting for enable
// S_SETTLE   | LED of current channel on, waiting for optical settle
// S_ADC_REQ  | one-cycle adc_start, LED still on
// S_ADC_WAIT | LED on, waiting for adc_done or the conversion timeout
// S_FIR_REQ  | one-cycle fir_start with latched sample and channel tag
// S_FIR_WAIT | waiting for fir_done (unbounded; may stretch the phase)
// S_HOLD     | LEDs off until the phase timer expires
module ppg_fir_scheduler #(
  parameter int PHASE_CYCLES  = 250000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int ADC_TIMEOUT   = 1000
) (
  input  logic                CLK_Filter,
  input  logic                rst,
  input  logic                enable,
  output logic                LED_IR,
  output logic                LED_RED,
  ppg_fir_scheduler_if.master bus,
  output logic [19:0]         Out_IR_Filtered,
  output logic [19:0]         Out_RED_Filtered,
  output logic                ir_valid,
  output logic                red_valid,
  output logic                adc_timeout_err
);

  localparam int PW = $clog2(PHASE_CYCLES + 1);
  localparam int TW = $clog2(ADC_TIMEOUT + 1);

  // Phase timer counts down the cycles left in the phase and parks at zero.
  localparam logic [PW-1:0] PHASE_LOAD  = PW'(PHASE_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_DONE = PW'(PHASE_CYCLES - SETTLE_CYCLES);
  localparam logic [TW-1:0] TMO_LOAD    = TW'(ADC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ADC_REQ,
    S_ADC_WAIT,
    S_FIR_REQ,
    S_FIR_WAIT,
    S_HOLD
  } state_t;

  state_t        state;
  logic          ch;
  logic [PW-1:0] phase_rem;
  logic [TW-1:0] tmo_rem;

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      state            <= S_IDLE;
      ch               <= 1'b0;
      phase_rem        <= '0;
      tmo_rem          <= '0;
      LED_IR           <= 1'b0;
      LED_RED          <= 1'b0;
      bus.adc_start    <= 1'b0;
      bus.fir_start    <= 1'b0;
      bus.fir_ch       <= 1'b0;
      bus.fir_sample   <= '0;
      Out_IR_Filtered  <= '0;
      Out_RED_Filtered <= '0;
      ir_valid         <= 1'b0;
      red_valid        <= 1'b0;
      adc_timeout_err  <= 1'b0;
    end else begin
      bus.adc_start <= 1'b0;
      bus.fir_start <= 1'b0;
      ir_valid      <= 1'b0;
      red_valid     <= 1'b0;

      if (state != S_IDLE && phase_rem != '0)
        phase_rem <= phase_rem - PW'(1);

      case (state)
        S_IDLE: begin
          if (enable) begin
            state     <= S_SETTLE;
            ch        <= 1'b0;
            phase_rem <= PHASE_LOAD;
            LED_IR    <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (phase_rem == SETTLE_DONE) begin
            state         <= S_ADC_REQ;
            bus.adc_start <= 1'b1;
          end
        end

        S_ADC_REQ: begin
          state   <= S_ADC_WAIT;
          tmo_rem <= TMO_LOAD;
        end

        S_ADC_WAIT: begin
          // A conversion landing on the last timeout cycle is still accepted.
          if (bus.adc_done) begin
            state          <= S_FIR_REQ;
            bus.fir_sample <= bus.ADC_Value;
            bus.fir_ch     <= ch;
            bus.fir_start  <= 1'b1;
            LED_IR         <= 1'b0;
            LED_RED        <= 1'b0;
          end else if (tmo_rem == '0) begin
            state           <= S_HOLD;
            adc_timeout_err <= 1'b1;
            LED_IR          <= 1'b0;
            LED_RED         <= 1'b0;
          end else begin
            tmo_rem <= tmo_rem - TW'(1);
          end
        end

        S_FIR_REQ: begin
          state <= S_FIR_WAIT;
        end

        S_FIR_WAIT: begin
          if (bus.fir_done) begin
            state <= S_HOLD;
            if (bus.fir_ch) begin
              Out_RED_Filtered <= bus.fir_result;
              red_valid        <= 1'b1;
            end else begin
              Out_IR_Filtered <= bus.fir_result;
              ir_valid        <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (phase_rem == '0) begin
            phase_rem <= PHASE_LOAD;
            if (enable) begin
              state   <= S_SETTLE;
              ch      <= ~ch;
              LED_IR  <= ch;
              LED_RED <= ~ch;
            end else begin
              state <= S_IDLE;
              ch    <= 1'b0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppg_fir_scheduler.sv
// Self-checking bench for ppg_fir_scheduler: each phase's timeline is predicted
// from offsets relative to LED turn-on and compared cycle by cycle.
module tb_ppg_fir_scheduler;
  localparam int P = 40;
  localparam int S = 4;
  localparam int T = 8;

  logic        CLK_Filter = 1'b0;
  logic        rst        = 1'b1;
  logic        enable     = 1'b0;
  logic        LED_IR, LED_RED, ir_valid, red_valid, adc_timeout_err;
  logic [19:0] Out_IR_Filtered, Out_RED_Filtered;

  ppg_fir_scheduler_if bus ();

  ppg_fir_scheduler #(
    .PHASE_CYCLES (P),
    .SETTLE_CYCLES(S),
    .ADC_TIMEOUT  (T)
  ) dut (
    .CLK_Filter      (CLK_Filter),
    .rst             (rst),
    .enable          (enable),
    .LED_IR          (LED_IR),
    .LED_RED         (LED_RED),
    .bus             (bus),
    .Out_IR_Filtered (Out_IR_Filtered),
    .Out_RED_Filtered(Out_RED_Filtered),
    .ir_valid        (ir_valid),
    .red_valid       (red_valid),
    .adc_timeout_err (adc_timeout_err)
  );

  always #5 CLK_Filter = ~CLK_Filter;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [19:0] m_out_ir  = '0;
  logic [19:0] m_out_red = '0;
  logic        m_err     = 1'b0;
  logic        cur_ch    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_cycle(input bit e_ir, input bit e_red, input bit e_as,
                           input bit e_fs, input bit e_iv, input bit e_rv);
    chk("LED_IR", 32'(LED_IR), 32'(e_ir));
    chk("LED_RED", 32'(LED_RED), 32'(e_red));
    chk("adc_start", 32'(bus.adc_start), 32'(e_as));
    chk("fir_start", 32'(bus.fir_start), 32'(e_fs));
    chk("ir_valid", 32'(ir_valid), 32'(e_iv));
    chk("red_valid", 32'(red_valid), 32'(e_rv));
    chk("Out_IR_Filtered", 32'(Out_IR_Filtered), 32'(m_out_ir));
    chk("Out_RED_Filtered", 32'(Out_RED_Filtered), 32'(m_out_red));
    chk("adc_timeout_err", 32'(adc_timeout_err), 32'(m_err));
  endtask

  // n idle cycles with LEDs dark; enable rises in the last one.
  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK_Filter);
      chk_cycle(0, 0, 0, 0, 0, 0);
      bus.adc_done  = 1'b0;
      bus.fir_done  = 1'b0;
      enable        = (i == n - 1);
    end
    cur_ch = 1'b0;
  endtask

  // One LED phase, k = cycles since LED turn-on. d: adc_done delay after
  // adc_start (accepted only if 1..T), f: fir_done delay after fir_start.
  task automatic do_phase(input logic ch, input int d, input int f,
                          input logic [7:0] smp, input logic [19:0] res,
                          input logic en_mid, input logic en_end, input int rst_k);
    bit acc;
    int fs_k, led_off, end_k;
    acc     = (d >= 1 && d <= T);
    fs_k    = S + d + 1;
    led_off = S + 1 + (acc ? d : T);
    end_k   = acc ? ((fs_k + f + 2 > P) ? fs_k + f + 2 : P) : P;
    for (int k = 0; k < end_k; k++) begin
      @(negedge CLK_Filter);
      if (acc && k == fs_k + f + 1) begin
        if (ch) m_out_red = res;
        else    m_out_ir  = res;
      end
      if (!acc && k == S + T + 1) m_err = 1'b1;
      chk_cycle(!ch && k < led_off, ch && k < led_off, k == S, acc && k == fs_k,
                acc && !ch && k == fs_k + f + 1, acc && ch && k == fs_k + f + 1);
      if (acc && k >= fs_k && k <= fs_k + f) begin
        chk("fir_ch", 32'(bus.fir_ch), 32'(ch));
        chk("fir_sample", 32'(bus.fir_sample), 32'(smp));
      end
      bus.adc_done   = (k == S + d) || (k == 1 && $urandom_range(1) == 1);
      bus.ADC_Value  = (k == S + d) ? smp : 8'($urandom);
      bus.fir_done   = (acc && k == fs_k + f) || (k == 2 && $urandom_range(1) == 1);
      bus.fir_result = (acc && k == fs_k + f) ? res : 20'($urandom);
      if (k == 2) enable = en_mid;
      if (k == end_k - 1) enable = en_end;
      if (k == rst_k) begin
        rst    = 1'b1;
        enable = 1'b0;
        return;
      end
    end
    cur_ch = en_end ? ~ch : 1'b0;
  endtask

  task automatic run_phase(input int d, input int f, input logic [7:0] smp,
                           input logic [19:0] res, input logic en_mid, input logic en_end);
    do_phase(cur_ch, d, f, smp, res, en_mid, en_end, -1);
    if (!en_end) idle_run(3);
  endtask

  initial begin
    bus.adc_done   = 1'b0;
    bus.ADC_Value  = '0;
    bus.fir_done   = 1'b0;
    bus.fir_result = '0;

    repeat (3) @(negedge CLK_Filter);
    chk_cycle(0, 0, 0, 0, 0, 0);
    chk("reset fir_ch", 32'(bus.fir_ch), 32'd0);
    chk("reset fir_sample", 32'(bus.fir_sample), 32'd0);
    rst = 1'b0;
    idle_run(3);

    // normal pair, then last-cycle acceptance, then a stretched phase
    run_phase(2, 3, 8'h55, 20'd1000, 1, 1);
    run_phase(2, 3, 8'hAA, 20'd2000, 1, 1);
    run_phase(T, 2, 8'h3C, 20'd12345, 1, 1);
    run_phase(3, 4, 8'hC3, 20'd54321, 1, 1);
    run_phase(2, 50, 8'h11, 20'hABCDE, 1, 1);
    run_phase(1, 1, 8'h22, 20'h12345, 1, 1);
    // IR conversion never completes; RED continues on schedule
    run_phase(100, 3, 8'h77, 20'd999, 1, 1);
    run_phase(2, 3, 8'h88, 20'd888, 1, 1);
    // enable dropped mid-RED: phase completes, then idle and restart on IR
    run_phase(2, 3, 8'h01, 20'd1, 1, 1);
    run_phase(2, 3, 8'h02, 20'd2, 0, 0);
    run_phase(2, 3, 8'h03, 20'd3, 1, 1);

    for (int i = 0; i < 30; i++) begin
      int   d, f;
      logic e_end;
      d     = $urandom_range(11, 0);
      f     = ($urandom_range(3) == 0) ? $urandom_range(50, 30) : $urandom_range(6, 1);
      e_end = ($urandom_range(5) != 0);
      run_phase(d, f, 8'($urandom), 20'($urandom), 1'($urandom), e_end);
    end

    // reset while the FIR is busy; the late fir_done must be discarded
    if (!enable) idle_run(2);
    do_phase(cur_ch, 2, 40, 8'h5A, 20'h0F0F0, 1, 1, S + 3 + 5);
    @(negedge CLK_Filter);
    m_out_ir  = '0;
    m_out_red = '0;
    m_err     = 1'b0;
    chk_cycle(0, 0, 0, 0, 0, 0);
    chk("rst fir_sample", 32'(bus.fir_sample), 32'd0);
    rst            = 1'b0;
    bus.fir_done   = 1'b1;
    bus.fir_result = 20'hFFFFF;
    repeat (3) begin
      @(negedge CLK_Filter);
      chk_cycle(0, 0, 0, 0, 0, 0);
      bus.fir_done = 1'b0;
    end
    idle_run(1);
    run_phase(2, 3, 8'h44, 20'd4444, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
